// File: rtl/qwi16_threadled_pkg.sv
// qwi16_threadled_pkg: shared state encoding and defaults for the LED arbiter
package qwi16_threadled_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, HANDOVER} arb_state_t;
  localparam logic [3:0] IDLE_PATTERN_DEF = 4'b0000;
endpackage

// File: rtl/qwi16_rr_pick.sv
// qwi16_rr_pick: round-robin pick of the first requester after last_owner
module qwi16_rr_pick #(
  parameter int N_REQ = 4,
  localparam int IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_owner,
  output logic [IW-1:0]    pick,
  output logic             any_req
);
  always_comb begin
    pick = '0;
    any_req = 1'b0;
    for (int k = 1; k <= N_REQ; k++)
      for (int i = 0; i < N_REQ; i++)
        if (!any_req && req[i] && (int'(last_owner) + k) % N_REQ == i) begin
          pick = IW'(i);
          any_req = 1'b1;
        end
  end
endmodule

// File: rtl/qwi16_led_arbiter.sv
// qwi16_led_arbiter: time-sliced round-robin sharing of the LED bank
module qwi16_led_arbiter
  import qwi16_threadled_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LED_W = 4,
  parameter int SLICE_W = 16,
  parameter logic [LED_W-1:0] IDLE_PATTERN = LED_W'(IDLE_PATTERN_DEF)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LED_W-1:0] led_val,
  input  logic [SLICE_W-1:0]     slice_len,
  output logic [N_REQ-1:0]       grant,
  output logic                   grant_valid,
  output logic                   switch_pulse,
  output logic [LED_W-1:0]       LED
);
  localparam int IW = $clog2(N_REQ);
  arb_state_t state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic switch_q, switch_d;
  logic [LED_W-1:0] led_q, led_d, own_led;
  logic [SLICE_W-1:0] cnt_q, cnt_d, slice_q, slice_d;
  logic [IW-1:0] last_q, last_d, pick;
  logic any_req, own_req, expire, others, load, hand;

  qwi16_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req(req),
    .last_owner(last_q),
    .pick(pick),
    .any_req(any_req)
  );

  always_comb begin
    own_led = IDLE_PATTERN;
    for (int i = 0; i < N_REQ; i++)
      if (last_q == IW'(i)) own_led = led_val[i*LED_W +: LED_W];
  end

  assign own_req = req[last_q];
  assign expire = cnt_q == slice_q - 1'b1;
  assign others = |(req & ~grant_q);
  assign load = any_req && state_q != GRANT;
  // release and expiry-with-contention both end the slice through one blank cycle
  assign hand = state_q == GRANT && (!own_req || (expire && others));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      switch_q <= 1'b0;
      led_q <= IDLE_PATTERN;
      cnt_q <= '0;
      slice_q <= '0;
      last_q <= IW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      switch_q <= switch_d;
      led_q <= led_d;
      cnt_q <= cnt_d;
      slice_q <= slice_d;
      last_q <= last_d;
    end

  always_comb begin
    state_d = load ? GRANT : hand ? HANDOVER : state_q == GRANT ? GRANT : IDLE;
    cnt_d = (state_q == GRANT && !hand && !expire) ? cnt_q + 1'b1 : '0;
    slice_d = load ? ((slice_len == '0) ? SLICE_W'(1) : slice_len) : slice_q;
    last_d = load ? pick : last_q;
  end

  always_comb begin
    grant_d = load ? N_REQ'(1) << pick : (state_q == GRANT && !hand) ? grant_q : '0;
    switch_d = load;
    led_d = state_q == GRANT ? own_led : IDLE_PATTERN;
  end

  assign grant = grant_q;
  assign grant_valid = |grant_q;
  assign switch_pulse = switch_q;
  assign LED = led_q;
endmodule

// File: tb/tb_qwi16_led_arbiter.sv
// tb_qwi16_led_arbiter: scoreboard bench for the LED arbiter
module tb_qwi16_led_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [15:0] led_val = 16'h3C5A;
  logic [15:0] slice_len = '0;
  logic [3:0] grant, led;
  logic grant_valid, switch_pulse;

  typedef struct {
    logic [3:0] g;
    logic sw;
    logic [3:0] l;
    int id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int checks = 0;
  int errors = 0;
  int step = 0;

  qwi16_led_arbiter dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .led_val(led_val),
    .slice_len(slice_len),
    .grant(grant),
    .grant_valid(grant_valid),
    .switch_pulse(switch_pulse),
    .LED(led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, id, act, exp);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("grant", mon_e.id, 32'(grant), 32'(mon_e.g));
      chk("grant_valid", mon_e.id, 32'(grant_valid), 32'(|mon_e.g));
      chk("switch_pulse", mon_e.id, 32'(switch_pulse), 32'(mon_e.sw));
      chk("led", mon_e.id, 32'(led), 32'(mon_e.l));
    end
  end

  task automatic cyc(input logic [3:0] r, input logic [15:0] s,
                     input logic [3:0] eg, input logic es, input logic [3:0] el);
    @(negedge clk);
    req = r;
    slice_len = s;
    sb.push_back('{eg, es, el, step});
    step++;
  endtask

  task automatic do_reset(input bit pre, input logic [3:0] pre_led);
    @(posedge clk);
    #2;
    if (pre) chk("pre_reset_led", step, 32'(led), 32'(pre_led));
    rst_n = 1'b0;
    #1;
    chk("rst_grant", step, 32'(grant), 32'h0);
    chk("rst_grant_valid", step, 32'(grant_valid), 32'h0);
    chk("rst_switch", step, 32'(switch_pulse), 32'h0);
    chk("rst_led", step, 32'(led), 32'h0);
    req = '0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    // single requester keeps the bank across slice boundaries
    do_reset(1'b0, 4'h0);
    cyc(4'b0001, 16'd8, 4'b0001, 1'b1, 4'h0);
    for (int i = 0; i < 11; i++) cyc(4'b0001, 16'd8, 4'b0001, 1'b0, 4'hA);
    // two requesters, slice 4, period 10
    do_reset(1'b0, 4'h0);
    cyc(4'b0101, 16'd4, 4'b0001, 1'b1, 4'h0);
    cyc(4'b0101, 16'd4, 4'b0001, 1'b0, 4'hA);
    cyc(4'b0101, 16'd4, 4'b0001, 1'b0, 4'hA);
    cyc(4'b0101, 16'd4, 4'b0001, 1'b0, 4'hA);
    cyc(4'b0101, 16'd4, 4'b0000, 1'b0, 4'hA);
    cyc(4'b0101, 16'd4, 4'b0100, 1'b1, 4'h0);
    cyc(4'b0101, 16'd4, 4'b0100, 1'b0, 4'hC);
    cyc(4'b0101, 16'd4, 4'b0100, 1'b0, 4'hC);
    cyc(4'b0101, 16'd4, 4'b0100, 1'b0, 4'hC);
    cyc(4'b0101, 16'd4, 4'b0000, 1'b0, 4'hC);
    cyc(4'b0101, 16'd4, 4'b0001, 1'b1, 4'h0);
    cyc(4'b0101, 16'd4, 4'b0001, 1'b0, 4'hA);
    // owner 2 releases early with requester 3 waiting
    do_reset(1'b0, 4'h0);
    cyc(4'b0100, 16'd16, 4'b0100, 1'b1, 4'h0);
    cyc(4'b0100, 16'd16, 4'b0100, 1'b0, 4'hC);
    cyc(4'b1100, 16'd16, 4'b0100, 1'b0, 4'hC);
    cyc(4'b1000, 16'd16, 4'b0000, 1'b0, 4'hC);
    cyc(4'b1000, 16'd16, 4'b1000, 1'b1, 4'h0);
    cyc(4'b1000, 16'd16, 4'b1000, 1'b0, 4'h3);
    // release on the expiry cycle with requester 1 pending
    do_reset(1'b0, 4'h0);
    cyc(4'b0001, 16'd2, 4'b0001, 1'b1, 4'h0);
    cyc(4'b0011, 16'd2, 4'b0001, 1'b0, 4'hA);
    cyc(4'b0010, 16'd2, 4'b0000, 1'b0, 4'hA);
    cyc(4'b0010, 16'd2, 4'b0010, 1'b1, 4'h0);
    cyc(4'b0010, 16'd2, 4'b0010, 1'b0, 4'h5);
    cyc(4'b0010, 16'd2, 4'b0010, 1'b0, 4'h5);
    // zero slice length rotates every cycle, including the 3->0 wrap
    do_reset(1'b0, 4'h0);
    cyc(4'b1111, 16'd0, 4'b0001, 1'b1, 4'h0);
    cyc(4'b1111, 16'd0, 4'b0000, 1'b0, 4'hA);
    cyc(4'b1111, 16'd0, 4'b0010, 1'b1, 4'h0);
    cyc(4'b1111, 16'd0, 4'b0000, 1'b0, 4'h5);
    cyc(4'b1111, 16'd0, 4'b0100, 1'b1, 4'h0);
    cyc(4'b1111, 16'd0, 4'b0000, 1'b0, 4'hC);
    cyc(4'b1111, 16'd0, 4'b1000, 1'b1, 4'h0);
    cyc(4'b1111, 16'd0, 4'b0000, 1'b0, 4'h3);
    cyc(4'b1111, 16'd0, 4'b0001, 1'b1, 4'h0);
    cyc(4'b1111, 16'd0, 4'b0000, 1'b0, 4'hA);
    // asynchronous reset mid-slice, then requester 0 wins first
    do_reset(1'b0, 4'h0);
    cyc(4'b0010, 16'd16, 4'b0010, 1'b1, 4'h0);
    cyc(4'b0010, 16'd16, 4'b0010, 1'b0, 4'h5);
    cyc(4'b0010, 16'd16, 4'b0010, 1'b0, 4'h5);
    do_reset(1'b1, 4'h5);
    cyc(4'b0011, 16'd4, 4'b0001, 1'b1, 4'h0);
    cyc(4'b0011, 16'd4, 4'b0001, 1'b0, 4'hA);
    @(posedge clk);
    #2;
    chk("sb_drained", step, 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
